// File: rtl/pb_pkg.sv
// Shared types, parameter defaults and counter-width helpers for the
// multi-channel push-button debouncer.
package pb_pkg;

  typedef enum logic [1:0] {
    HOLD_RELEASED = 2'd0,
    HOLD_HELD     = 2'd1,
    HOLD_LONG     = 2'd2
  } hold_state_t;

  localparam int DEF_NUM_BTN    = 4;
  localparam int DEF_TICK_DIV   = 50000;
  localparam int DEF_DEBOUNCE_T = 20;
  localparam int DEF_LONG_T     = 1000;
  localparam int DEF_REPEAT_T   = 200;
  localparam int DEF_EXCLUSIVE  = 1;

  // Width of a counter that runs 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // A zero repeat period still needs a one-bit counter.
  function automatic int rep_width(input int repeat_t);
    return cnt_width((repeat_t > 1) ? repeat_t : 1);
  endfunction

endpackage

// File: rtl/pb_channel.sv
// One button channel: synchroniser, tick debouncer, hold FSM with long-press
// and auto-repeat, and the registered event pulses gated by the valid flag.
module pb_channel
  import pb_pkg::*;
#(
  parameter int DEBOUNCE_T = DEF_DEBOUNCE_T,
  parameter int LONG_T     = DEF_LONG_T,
  parameter int REPEAT_T   = DEF_REPEAT_T
) (
  input  logic clkin_50,
  input  logic rst,
  input  logic tick,
  input  logic pb_n,
  input  logic grant,
  output logic accept,
  output logic valid,
  output logic lvl,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int DB_W   = cnt_width(DEBOUNCE_T);
  localparam int HOLD_W = cnt_width(LONG_T);
  localparam int REP_W  = rep_width(REPEAT_T);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_T - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_T - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'((REPEAT_T > 0) ? REPEAT_T - 1 : 0);

  logic [1:0]        sync_q;
  logic              sync;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [REP_W-1:0]  rep_cnt;
  logic              db_done, rise, fall, hold_last, rep_last;
  logic              press_d, release_d, long_d, repeat_d;
  hold_state_t       state, state_nxt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clkin_50) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], ~pb_n};
  end

  assign sync    = sync_q[1];
  assign db_done = tick && (sync != lvl) && (db_cnt == DB_LAST);
  assign rise    = db_done && !lvl;
  assign fall    = db_done && lvl;
  assign accept  = rise;

  always_ff @(posedge clkin_50) begin
    if (rst) begin
      db_cnt <= '0;
      lvl    <= 1'b0;
    end else if (sync == lvl) begin
      db_cnt <= '0;
    end else if (tick) begin
      if (db_cnt == DB_LAST) begin
        lvl    <= ~lvl;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign hold_last = tick && (hold_cnt == HOLD_LAST);
  assign rep_last  = (REPEAT_T > 0) && tick && (rep_cnt == REP_LAST);

  always_ff @(posedge clkin_50) begin
    if (rst) state <= HOLD_RELEASED;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first, so no path leaves state_nxt unassigned
    // and no latch is inferred.
    state_nxt = state;
    case (state)
      HOLD_RELEASED: if (rise) state_nxt = HOLD_HELD;
      HOLD_HELD: begin
        if (fall)           state_nxt = HOLD_RELEASED;
        else if (hold_last) state_nxt = HOLD_LONG;
      end
      HOLD_LONG:     if (fall) state_nxt = HOLD_RELEASED;
      default:       state_nxt = HOLD_RELEASED;
    endcase
  end

  // A release on the same tick as a long/repeat boundary wins over the pulse.
  always_comb begin
    press_d   = rise && grant;
    release_d = fall && valid;
    long_d    = (state == HOLD_HELD) && !fall && hold_last && valid;
    repeat_d  = (state == HOLD_LONG) && !fall && rep_last && valid;
  end

  always_ff @(posedge clkin_50) begin
    if (rst) begin
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else begin
      if (rise)                               hold_cnt <= '0;
      else if (state == HOLD_HELD && tick)    hold_cnt <= hold_cnt + 1'b1;

      if (state == HOLD_HELD && hold_last)    rep_cnt <= '0;
      else if (state == HOLD_LONG && tick)    rep_cnt <= rep_last ? '0 : rep_cnt + 1'b1;
    end
  end

  always_ff @(posedge clkin_50) begin
    if (rst) begin
      valid         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      if (rise)      valid <= grant;
      else if (fall) valid <= 1'b0;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      long_pulse    <= long_d;
      repeat_pulse  <= repeat_d;
    end
  end

endmodule

// File: rtl/pb_debounce_multi.sv
// N-button front end: shared tick prescaler, per-channel debounce/hold logic
// and the priority arbiter that enforces single-button exclusivity.
module pb_debounce_multi
  import pb_pkg::*;
#(
  parameter int NUM_BTN    = DEF_NUM_BTN,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int DEBOUNCE_T = DEF_DEBOUNCE_T,
  parameter int LONG_T     = DEF_LONG_T,
  parameter int REPEAT_T   = DEF_REPEAT_T,
  parameter int EXCLUSIVE  = DEF_EXCLUSIVE
) (
  input  logic               clkin_50,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] pb_n,
  output logic [NUM_BTN-1:0] btn_lvl,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long,
  output logic [NUM_BTN-1:0] btn_repeat
);

  localparam int                TICK_W    = cnt_width(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0]  tick_cnt;
  logic               tick;
  logic [NUM_BTN-1:0] accept, valid, grant;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clkin_50) begin
    if (rst) tick_cnt <= '0;
    else     tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  // A press is granted only if no other channel owns the buttons and no
  // lower-index channel is being accepted in the same cycle.
  always_comb begin
    grant = '1;
    if (EXCLUSIVE != 0) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        for (int j = 0; j < NUM_BTN; j++) begin
          if (j != i && valid[j]) grant[i] = 1'b0;
          if (j < i && accept[j]) grant[i] = 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    pb_channel #(
      .DEBOUNCE_T(DEBOUNCE_T),
      .LONG_T    (LONG_T),
      .REPEAT_T  (REPEAT_T)
    ) u_ch (
      .clkin_50     (clkin_50),
      .rst          (rst),
      .tick         (tick),
      .pb_n         (pb_n[g]),
      .grant        (grant[g]),
      .accept       (accept[g]),
      .valid        (valid[g]),
      .lvl          (btn_lvl[g]),
      .press_pulse  (btn_press[g]),
      .release_pulse(btn_release[g]),
      .long_pulse   (btn_long[g]),
      .repeat_pulse (btn_repeat[g])
    );
  end

endmodule

// File: tb/tb_pb_debounce_multi.sv
// Directed bench for pb_debounce_multi: table-driven phases counting pulses
// per channel, plus hand sequences for bounce, reset mid-hold and glitches.
module tb_pb_debounce_multi;

  localparam int NB = 4;
  localparam int TD = 4;
  localparam int DB = 3;
  localparam int LT = 10;
  localparam int RT = 5;

  logic          clkin_50 = 1'b0;
  logic          rst      = 1'b0;
  logic [NB-1:0] pb_n     = '1;
  logic [NB-1:0] btn_lvl, btn_press, btn_release, btn_long, btn_repeat;

  pb_debounce_multi #(
    .NUM_BTN(NB), .TICK_DIV(TD), .DEBOUNCE_T(DB),
    .LONG_T(LT), .REPEAT_T(RT), .EXCLUSIVE(1)
  ) dut (
    .clkin_50   (clkin_50),
    .rst        (rst),
    .pb_n       (pb_n),
    .btn_lvl    (btn_lvl),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long),
    .btn_repeat (btn_repeat)
  );

  always #5 clkin_50 = ~clkin_50;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clkin_50) cyc <= cyc + 1;

  // Pulse monitor: cumulative per-channel counts and invariant violations.
  int n_press[NB], n_rel[NB], n_long[NB], n_rep[NB], n_hi[NB], last_ev[NB];
  int last_press = 0, last_rel = 0, last_long = 0;
  int viol_edge = 0, viol_spacing = 0, viol_coincide = 0;
  logic [NB-1:0] prev_lvl = '0;

  always @(negedge clkin_50) begin
    for (int c = 0; c < NB; c++) begin
      if (btn_lvl[c]) n_hi[c] <= n_hi[c] + 1;
      if (btn_press[c]) begin
        n_press[c] <= n_press[c] + 1;
        last_press <= cyc;
        if (!(btn_lvl[c] && !prev_lvl[c])) viol_edge <= viol_edge + 1;
      end
      if (btn_release[c]) begin
        n_rel[c] <= n_rel[c] + 1;
        last_rel <= cyc;
        if (!(!btn_lvl[c] && prev_lvl[c])) viol_edge <= viol_edge + 1;
      end
      if (btn_long[c]) begin
        n_long[c]  <= n_long[c] + 1;
        last_long  <= cyc;
        last_ev[c] <= cyc;
        if (btn_repeat[c]) viol_coincide <= viol_coincide + 1;
      end
      if (btn_repeat[c]) begin
        n_rep[c]   <= n_rep[c] + 1;
        last_ev[c] <= cyc;
        if (cyc - last_ev[c] != RT * TD) viol_spacing <= viol_spacing + 1;
      end
    end
    prev_lvl <= btn_lvl;
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, got, exp);
    end
  endtask

  function automatic int total_pulses();
    int t = 0;
    for (int c = 0; c < NB; c++) t += n_press[c] + n_rel[c] + n_long[c] + n_rep[c];
    return t;
  endfunction

  // Count fields hold one nibble per channel (channel 0 in the low nibble).
  typedef struct {
    logic [3:0]  pb_n;
    int          cycles;
    logic [3:0]  lvl;
    logic [15:0] press;
    logic [15:0] rel;
    logic [15:0] lng;
    logic [15:0] rep;
    int          press_at;
    int          rel_at;
    int          long_at;
  } vec_t;

  vec_t vecs[11];

  task automatic run_vec(input int idx);
    vec_t v;
    int bp[NB], br[NB], bl[NB], bq[NB];
    int tp, tr, tl, start;
    logic [15:0] gp, gr, gl, gq;
    v = vecs[idx];
    for (int c = 0; c < NB; c++) begin
      bp[c] = n_press[c]; br[c] = n_rel[c]; bl[c] = n_long[c]; bq[c] = n_rep[c];
    end
    start = cyc;
    pb_n  = v.pb_n;
    repeat (v.cycles) @(posedge clkin_50);
    #1;
    tp = 0; tr = 0; tl = 0;
    gp = '0; gr = '0; gl = '0; gq = '0;
    for (int c = 0; c < NB; c++) begin
      gp[4*c +: 4] = 4'(n_press[c] - bp[c]);
      gr[4*c +: 4] = 4'(n_rel[c] - br[c]);
      gl[4*c +: 4] = 4'(n_long[c] - bl[c]);
      gq[4*c +: 4] = 4'(n_rep[c] - bq[c]);
      tp += n_press[c] - bp[c];
      tr += n_rel[c] - br[c];
      tl += n_long[c] - bl[c];
    end
    check($sformatf("v%0d_lvl", idx), int'(btn_lvl), int'(v.lvl));
    check($sformatf("v%0d_press", idx), int'(gp), int'(v.press));
    check($sformatf("v%0d_release", idx), int'(gr), int'(v.rel));
    check($sformatf("v%0d_long", idx), int'(gl), int'(v.lng));
    check($sformatf("v%0d_repeat", idx), int'(gq), int'(v.rep));
    check($sformatf("v%0d_press_at", idx), (tp > 0) ? last_press - start : -1, v.press_at);
    check($sformatf("v%0d_release_at", idx), (tr > 0) ? last_rel - start : -1, v.rel_at);
    check($sformatf("v%0d_long_at", idx), (tl > 0) ? last_long - start : -1, v.long_at);
  endtask

  initial begin
    int base, start;

    // Press lands 12 cycles (3 ticks) after a phase edge; long 40 and
    // repeats every 20 cycles after that.
    vecs[0]  = '{4'hF, 16,  4'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, -1, -1, -1};
    vecs[1]  = '{4'hE, 176, 4'h1, 16'h0001, 16'h0000, 16'h0001, 16'h0006, 12, -1, 52};
    vecs[2]  = '{4'hF, 40,  4'h0, 16'h0000, 16'h0001, 16'h0000, 16'h0000, -1, 12, -1};
    vecs[3]  = '{4'hF, 40,  4'h0, 16'h0000, 16'h0010, 16'h0000, 16'h0000, -1, 12, -1};
    vecs[4]  = '{4'hB, 176, 4'h4, 16'h0100, 16'h0000, 16'h0100, 16'h0600, 12, -1, 52};
    vecs[5]  = '{4'hF, 40,  4'h0, 16'h0000, 16'h0100, 16'h0000, 16'h0000, -1, 12, -1};
    vecs[6]  = '{4'hE, 40,  4'h1, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 12, -1, -1};
    vecs[7]  = '{4'h6, 96,  4'h9, 16'h0000, 16'h0000, 16'h0001, 16'h0004, -1, -1, 12};
    vecs[8]  = '{4'hF, 40,  4'h0, 16'h0000, 16'h0001, 16'h0000, 16'h0000, -1, 12, -1};
    vecs[9]  = '{4'h9, 40,  4'h6, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 12, -1, -1};
    vecs[10] = '{4'hF, 40,  4'h0, 16'h0000, 16'h0010, 16'h0000, 16'h0000, -1, 12, -1};

    rst  = 1'b1;
    pb_n = '1;
    repeat (3) @(posedge clkin_50);
    #1;
    rst = 1'b0;
    check("reset_outputs", int'({btn_lvl, btn_press, btn_release, btn_long, btn_repeat}), 0);

    // Clean press, long/repeat and release on channel 0.
    for (int i = 0; i <= 2; i++) run_vec(i);

    // Bounce on channel 1: toggle every 3 cycles for 40 cycles, then hold low.
    base = total_pulses();
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) pb_n[1] = ~pb_n[1];
      @(posedge clkin_50);
      #1;
    end
    check("bounce_quiet", total_pulses() - base, 0);
    base    = n_press[1];
    start   = cyc;
    pb_n[1] = 1'b0;
    repeat (24) @(posedge clkin_50);
    #1;
    check("bounce_press_count", n_press[1] - base, 1);
    check("bounce_press_window",
          int'((last_press - start >= 2 * TD) && (last_press - start <= 4 * TD)), 1);
    check("bounce_lvl", int'(btn_lvl), 4'h2);

    // Release ch1, long/repeat on ch2, exclusivity scenarios.
    for (int i = 3; i <= 10; i++) run_vec(i);

    // Reset while channel 0 is in the long-press state.
    base = n_long[0];
    pb_n = 4'hE;
    repeat (60) @(posedge clkin_50);
    #1;
    check("rst_reached_long", n_long[0] - base, 1);
    check("rst_lvl_before", int'(btn_lvl), 4'h1);
    base = n_rel[0];
    rst  = 1'b1;
    @(posedge clkin_50);
    #1;
    rst = 1'b0;
    check("rst_clears_outputs", int'({btn_lvl, btn_press, btn_release, btn_long, btn_repeat}), 0);
    start = cyc;
    begin
      int bp0;
      bp0 = n_press[0];
      repeat (20) @(posedge clkin_50);
      #1;
      check("rst_repress_count", n_press[0] - bp0, 1);
      check("rst_repress_at", last_press - start, 3 * TD);
    end
    check("rst_no_release", n_rel[0] - base, 0);
    pb_n = 4'hF;
    repeat (40) @(posedge clkin_50);
    #1;
    check("rst_later_release", n_rel[0] - base, 1);

    // Short glitches on channel 3 must not reach the debounced level.
    base = n_press[3] + n_rel[3] + n_long[3] + n_rep[3] + n_hi[3];
    for (int g = 0; g < 2; g++) begin
      pb_n[3] = 1'b0;
      repeat (3) @(posedge clkin_50);
      #1;
      pb_n[3] = 1'b1;
      repeat (10) @(posedge clkin_50);
      #1;
    end
    repeat (20) @(posedge clkin_50);
    #1;
    check("glitch_ch3_activity", n_press[3] + n_rel[3] + n_long[3] + n_rep[3] + n_hi[3] - base, 0);
    check("glitch_lvl", int'(btn_lvl), 0);

    check("pulse_edge_alignment", viol_edge, 0);
    check("repeat_spacing", viol_spacing, 0);
    check("long_repeat_coincide", viol_coincide, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
